mult_div_seq: RTL
=================

MULT_DIV_SEQ -- requirements
Module: mult_div_seq

Interface
REQ-001 Parameter: DATA_W, default 32, operand and HI/LO width; only 32 is supported.
REQ-002 Port: clk  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  reset, synchronous, active-low.
REQ-004 Port: start  input  1  request pulse; sampled only in IDLE.
REQ-005 Port: op  input  1  operation select: 0 = MULT, 1 = DIV; sampled with start.
REQ-006 Port: a  input  32  multiplicand/dividend (rs value); sampled with start.
REQ-007 Port: b  input  32  multiplier/divisor (rt value); sampled with start.
REQ-008 Port: busy  output  1  high whenever state is not IDLE; the control FSM holds PC/IR writes while high.
REQ-009 Port: done  output  1  single-cycle completion pulse.
REQ-010 Port: div_zero  output  1  single-cycle pulse; DIV with b == 0, routed to the exception path and EPC.
REQ-011 Port: hi  output  32  HI register, fed to the MemtoReg mux for mfhi.
REQ-012 Port: lo  output  32  LO register, fed to the MemtoReg mux for mflo.

Function
REQ-013 States SHALL be IDLE, MULT, DIV, DONE; busy = (state != IDLE).
REQ-014 In IDLE, start=1 at edge k SHALL latch a, b and op, clear the iteration counter, and enter MULT or DIV at k.
REQ-015 start SHALL be ignored in any state other than IDLE, including DONE; operand changes after acceptance SHALL have no effect.
REQ-016 MULT SHALL use signed radix-2 Booth: one iteration per cycle, 32 iterations, 6-bit counter 0..31, then DONE.
REQ-017 DIV SHALL use restoring division on operand magnitudes: one quotient bit per cycle, 32 iterations, then sign correction on entry to DONE.
REQ-018 DIV results: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
REQ-019 DIV 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000 and HI=0 (wrap), with no flag.
REQ-020 MULT result: {hi,lo} = full signed 64-bit product; no overflow flag.
REQ-021 Latency: start accepted in cycle 0 -> busy high in cycles 1..33; DONE in cycle 33; done=1 in cycle 33 only; IDLE again in cycle 34.
REQ-022 hi/lo SHALL update only on the edge that enters DONE; they hold their value otherwise, including during an operation.
REQ-023 DIV with b == 0 SHALL skip iteration: go IDLE->DONE; done=1 and div_zero=1 in cycle 1 only; hi/lo unchanged.
REQ-024 div_zero SHALL never assert for MULT or for a nonzero divisor.
REQ-025 DONE SHALL always transition to IDLE on the next edge.

Reset
REQ-026 With reset=0 at a rising edge: state=IDLE, counter=0, hi=0, lo=0, done=0, div_zero=0, busy=0.
REQ-027 Reset during MULT/DIV/DONE SHALL abort the operation; no done or div_zero pulse follows; hi/lo = 0.
REQ-028 start asserted in the same cycle as reset=0 SHALL be discarded.

Structure
REQ-029 Shared package cpu_pkg SHALL hold DATA_W, the state enum (IDLE/MULT/DIV/DONE), and the op constants OP_MULT=0, OP_DIV=1.
REQ-030 One sub-module, div_step, SHALL implement a single combinational restoring-division iteration (partial remainder, quotient bit); Booth logic stays inline.
REQ-031 Working registers: 65-bit Booth accumulator, 64-bit remainder/quotient pair, sign bits, counter.

Verification
REQ-032 MULT a=7, b=0xFFFFFFFD -> cycle 33: done=1, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy cycles 1..33.
REQ-033 MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-034 DIV a=0xFFFFFFF9 (-7), b=2 -> cycle 33: lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0.
REQ-035 DIV a=5, b=0 with prior hi=0x11, lo=0x22 -> cycle 1: done=1, div_zero=1; hi=0x11, lo=0x22 unchanged; IDLE in cycle 2.
REQ-036 MULT started, reset=0 in cycle 10 -> cycle 11: busy=0, hi=lo=0; no done pulse within 40 cycles.
REQ-037 start re-pulsed with new a/b in cycles 5 and 33 of a DIV 100/7 -> only the first operation runs; lo=14, hi=2; second start ignored.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the sequential multiply/divide unit: width, FSM states,
// operation encodings and a magnitude helper used by the divider.
package cpu_pkg;
  localparam int DATA_W = 32;

  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  typedef enum logic [1:0] {IDLE, MULT, DIV, DONE} state_t;

  function automatic logic [DATA_W-1:0] mag(input logic [DATA_W-1:0] v);
    return v[DATA_W-1] ? (~v + 1'b1) : v;
  endfunction
endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes: shift in the next
// dividend bit, trial-subtract the divisor, keep the difference if it fits.
module div_step
  import cpu_pkg::*;
(
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] quo,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quo_next
);
  logic [DATA_W:0] shifted;
  logic [DATA_W:0] diff;
  logic            fits;

  // rem < divisor <= 2^31, so shifted never reaches bit DATA_W and a borrow shows there
  assign shifted  = {rem, quo[DATA_W-1]};
  assign diff     = shifted - {1'b0, divisor};
  assign fits     = ~diff[DATA_W];
  assign rem_next = fits ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
  assign quo_next = {quo[DATA_W-2:0], fits};
endmodule

// File: rtl/mult_div_seq.sv
// Sequential signed MULT (radix-2 Booth) / DIV (restoring) unit writing HI/LO;
// 32 iterations per operation, results land on the edge that enters DONE.
module mult_div_seq
  import cpu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              busy,
  output logic              done,
  output logic              div_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);
  state_t              state;
  logic [5:0]          cnt;
  logic [2*DATA_W:0]   acc;
  logic [2*DATA_W-1:0] rq;
  logic [DATA_W-1:0]   opnd;
  logic                sa, sb;

  logic [DATA_W:0]     a_ext, m_ext, bsum;
  logic [2*DATA_W:0]   booth_next;
  logic [DATA_W-1:0]   rem_next, quo_next, q_fix, r_fix;

  assign busy = (state != IDLE);

  // Upper half is widened by one bit so adding/subtracting 0x80000000 cannot overflow
  always_comb begin
    a_ext = {acc[2*DATA_W], acc[2*DATA_W:DATA_W+1]};
    m_ext = {opnd[DATA_W-1], opnd};
    bsum  = a_ext;
    case (acc[1:0])
      2'b01:   bsum = a_ext + m_ext;
      2'b10:   bsum = a_ext - m_ext;
      default: bsum = a_ext;
    endcase
    booth_next = {bsum, acc[DATA_W:1]};
  end

  div_step u_div_step (
    .rem      (rq[2*DATA_W-1:DATA_W]),
    .quo      (rq[DATA_W-1:0]),
    .divisor  (opnd),
    .rem_next (rem_next),
    .quo_next (quo_next)
  );

  assign q_fix = (sa ^ sb) ? (~quo_next + 1'b1) : quo_next;
  assign r_fix = sa ? (~rem_next + 1'b1) : rem_next;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      acc      <= '0;
      rq       <= '0;
      opnd     <= '0;
      sa       <= 1'b0;
      sb       <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state)
        IDLE: if (start) begin
          cnt <= '0;
          sa  <= a[DATA_W-1];
          sb  <= b[DATA_W-1];
          if (op == OP_DIV) begin
            if (b == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              div_zero <= 1'b1;
            end else begin
              state <= DIV;
              opnd  <= mag(b);
              rq    <= {{DATA_W{1'b0}}, mag(a)};
            end
          end else begin
            state <= MULT;
            opnd  <= a;
            acc   <= {{DATA_W{1'b0}}, b, 1'b0};
          end
        end
        MULT: begin
          acc <= booth_next;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= booth_next[2*DATA_W:DATA_W+1];
            lo    <= booth_next[DATA_W:1];
          end
        end
        DIV: begin
          rq  <= {rem_next, quo_next};
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            state <= DONE;
            done  <= 1'b1;
            hi    <= r_fix;
            lo    <= q_fix;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
